pri_arb: RTL and testbench

Parametrised, registered priority arbiter built around an N-to-log2(N) priority encoder. It samples an N-bit request vector, selects one channel by fixed (highest-index-wins) or round-robin priority, and holds that grant until the consumer acknowledges it or the request drops. It sits between request sources and a shared resource, replacing bare combinational encoders wherever the selection must be stable across cycles.

---
 rtl/pri_pkg.sv | 14 +
 rtl/pri_enc_core.sv | 44 ++++
 rtl/pri_arb.sv | 128 ++++++++++++
 tb/tb_pri_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared types and constants for the registered priority arbiter.
package pri_pkg;

    // Arbiter control states.
    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Arbitration policy selectors for the MODE parameter.
    localparam int unsigned PRI_FIXED = 0;
    localparam int unsigned PRI_RR    = 1;

endpackage

// File: rtl/pri_enc_core.sv
// Combinational N-input priority encoder.
// Fixed mode: highest set bit wins.
// Round-robin mode: priority descends from ptr_i, wrapping from 0 to N-1.
module pri_enc_core #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 mode_i,
    output logic                 any_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned W = $clog2(N);

    logic [N-1:0] rot;
    logic [W-1:0] hi;
    logic [W-1:0] src;

    // Rotate so that channel ptr lands on the top bit; rot[j] = req[ptr + j + 1 mod N].
    always_comb begin
        rot = req_i;
        src = '0;
        if (mode_i) begin
            for (int j = 0; j < N; j++) begin
                src    = ptr_i + W'(j) + W'(1);
                rot[j] = req_i[src];
            end
        end
    end

    // Highest set bit of the (possibly rotated) vector, then undo the rotation.
    always_comb begin
        hi = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                hi = W'(j);
            end
        end
        any_o = |req_i;
        idx_o = mode_i ? (hi + ptr_i + W'(1)) : hi;
    end

endmodule

// File: rtl/pri_arb.sv
// Registered priority arbiter: selects one requesting channel by fixed or
// round-robin priority and holds it until ack, withdrawal or disable.
module pri_arb
    import pri_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned MODE = PRI_FIXED
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [N-1:0]         req_i,
    input  logic                 ack_i,
    output logic                 grant_valid_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic [N-1:0]         grant_oh_o
);

    localparam int unsigned W = $clog2(N);
    localparam logic IsRr = (MODE == PRI_RR);

    arb_state_e   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] oh_q, oh_d;
    logic         valid_q, valid_d;

    logic [W-1:0] enc_ptr;
    logic         enc_any;
    logic [W-1:0] enc_idx;
    logic [W-1:0] served_ptr;
    logic         grant_ack;

    // Pointer that makes the just-served channel lowest priority.
    assign served_ptr = idx_q - W'(1);
    assign grant_ack  = (state_q == StGrant) && ack_i;

    // On ack the encoder must already see the updated pointer for back-to-back grants.
    assign enc_ptr = grant_ack ? served_ptr : ptr_q;

    pri_enc_core #(
        .N (N)
    ) u_enc (
        .req_i  (req_i),
        .ptr_i  (enc_ptr),
        .mode_i (IsRr),
        .any_o  (enc_any),
        .idx_o  (enc_idx)
    );

    // Next-state, pointer and registered-output selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (en_i && enc_any) begin
                    state_d       = StGrant;
                    valid_d       = 1'b1;
                    idx_d         = enc_idx;
                    oh_d          = '0;
                    oh_d[enc_idx] = 1'b1;
                end
            end
            StGrant: begin
                if (!en_i || !req_i[idx_q]) begin
                    // Disable beats withdrawal beats ack; neither moves the pointer.
                    state_d = StIdle;
                    valid_d = 1'b0;
                    idx_d   = '0;
                    oh_d    = '0;
                end else if (ack_i) begin
                    if (IsRr) begin
                        ptr_d = served_ptr;
                    end
                    if (enc_any) begin
                        idx_d         = enc_idx;
                        oh_d          = '0;
                        oh_d[enc_idx] = 1'b1;
                    end else begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        oh_d    = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                idx_d   = '0;
                oh_d    = '0;
            end
        endcase
    end

    // State, pointer and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            valid_q <= valid_d;
        end
    end

    assign grant_valid_o = valid_q;
    assign grant_idx_o   = idx_q;
    assign grant_oh_o    = oh_q;

    // One-hot output is empty without a grant and matches the index with one.
    a_oh_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_q || (oh_q == '0));
    a_oh_match : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !valid_q || (oh_q == (N'(1) << idx_q)));

endmodule

// File: tb/tb_pri_arb.sv
// Directed bench for pri_arb: one fixed-priority and one round-robin instance
// driven from the same stimulus, each checked in its own phase.
module tb_pri_arb;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         ack;

    logic         fx_valid, rr_valid;
    logic [W-1:0] fx_idx, rr_idx;
    logic [N-1:0] fx_oh, rr_oh;

    int n_checks;
    int n_fails;

    pri_arb #(
        .N    (N),
        .MODE (0)
    ) u_fx (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .req_i         (req),
        .ack_i         (ack),
        .grant_valid_o (fx_valid),
        .grant_idx_o   (fx_idx),
        .grant_oh_o    (fx_oh)
    );

    pri_arb #(
        .N    (N),
        .MODE (1)
    ) u_rr (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .req_i         (req),
        .ack_i         (ack),
        .grant_valid_o (rr_valid),
        .grant_idx_o   (rr_idx),
        .grant_oh_o    (rr_oh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rot_seq[8] = '{7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        ack   = 1'b0;
        tick();
        tick();
        check_eq("rst_fx_valid", 32'(fx_valid), 32'd0);
        check_eq("rst_fx_idx", 32'(fx_idx), 32'd0);
        check_eq("rst_fx_oh", 32'(fx_oh), 32'd0);
        check_eq("rst_rr_valid", 32'(rr_valid), 32'd0);
        rst_n = 1'b1;

        // Reset mid-grant.
        en  = 1'b1;
        req = 8'b1000_0000;
        tick();
        check_eq("mid_pre_valid", 32'(fx_valid), 32'd1);
        check_eq("mid_pre_idx", 32'(fx_idx), 32'd7);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", 32'(fx_valid), 32'd0);
        check_eq("mid_rst_idx", 32'(fx_idx), 32'd0);
        check_eq("mid_rst_oh", 32'(fx_oh), 32'd0);
        check_eq("mid_rst_rr_valid", 32'(rr_valid), 32'd0);
        rst_n = 1'b1;
        req   = '0;
        tick();

        // Fixed-mode selection and re-grant after ack.
        req = 8'b0010_1001;
        tick();
        check_eq("fx_sel_valid", 32'(fx_valid), 32'd1);
        check_eq("fx_sel_idx", 32'(fx_idx), 32'd5);
        check_eq("fx_sel_oh", 32'(fx_oh), 32'h20);
        req = 8'b0010_1011;  // non-granted bit change has no effect
        tick();
        check_eq("fx_hold_idx", 32'(fx_idx), 32'd5);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("fx_regrant_valid", 32'(fx_valid), 32'd1);
        check_eq("fx_regrant_idx", 32'(fx_idx), 32'd5);
        req = 8'b0000_1001;
        tick();
        check_eq("fx_wd_valid", 32'(fx_valid), 32'd0);
        check_eq("fx_wd_oh", 32'(fx_oh), 32'd0);
        tick();
        check_eq("fx_next_valid", 32'(fx_valid), 32'd1);
        check_eq("fx_next_idx", 32'(fx_idx), 32'd3);
        check_eq("fx_next_oh", 32'(fx_oh), 32'h08);

        // Enable gating and empty request.
        en  = 1'b0;
        req = 8'h81;
        tick();
        check_eq("en0_drop_valid", 32'(fx_valid), 32'd0);
        tick();
        check_eq("en0_hold_valid", 32'(fx_valid), 32'd0);
        en = 1'b1;
        tick();
        check_eq("en1_valid", 32'(fx_valid), 32'd1);
        check_eq("en1_idx", 32'(fx_idx), 32'd7);
        req = '0;
        tick();
        check_eq("req0_drop_valid", 32'(fx_valid), 32'd0);
        tick();
        check_eq("req0_idle_valid", 32'(fx_valid), 32'd0);

        // Round-robin rotation from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        check_eq("rr_first_valid", 32'(rr_valid), 32'd1);
        check_eq("rr_first_idx", 32'(rr_idx), 32'd0);
        check_eq("rr_first_oh", 32'(rr_oh), 32'h01);
        ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("rr_rot%0d_valid", i), 32'(rr_valid), 32'd1);
            check_eq($sformatf("rr_rot%0d_idx", i), 32'(rr_idx), 32'(rot_seq[i]));
        end
        // Grant 0 held, ptr 0; two more acks reach grant 6 with ptr 6.
        tick();
        check_eq("rr_to7_idx", 32'(rr_idx), 32'd7);
        tick();
        ack = 1'b0;
        check_eq("rr_to6_idx", 32'(rr_idx), 32'd6);
        check_eq("rr_to6_oh", 32'(rr_oh), 32'h40);

        // Withdrawal of channel 6: drop, ptr stays 6, so 0 beats 7 next.
        req = 8'h81;
        tick();
        check_eq("rr_wd_valid", 32'(rr_valid), 32'd0);
        tick();
        check_eq("rr_after_wd_valid", 32'(rr_valid), 32'd1);
        check_eq("rr_after_wd_idx", 32'(rr_idx), 32'd0);

        // ack together with en=0: dropped without moving ptr (still 6).
        ack = 1'b1;
        en  = 1'b0;
        tick();
        ack = 1'b0;
        check_eq("rr_ack_en0_valid", 32'(rr_valid), 32'd0);
        en = 1'b1;
        tick();
        check_eq("rr_ptr_kept_valid", 32'(rr_valid), 32'd1);
        check_eq("rr_ptr_kept_idx", 32'(rr_idx), 32'd0);

        // Ack with only the served channel requesting: re-granted, ptr now 7.
        req = 8'h01;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("rr_self_idx", 32'(rr_idx), 32'd0);
        req = 8'h81;
        tick();
        check_eq("rr_hold_idx", 32'(rr_idx), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("rr_ptr7_idx", 32'(rr_idx), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
